// File: rtl/param_sp_memory_if.sv
// Request/response bundle for the single-port storage block.
// The master drives requests; the slave (the memory) returns read data and status.
interface param_sp_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                    en;
  logic                    wr_en;
  logic [DATA_WIDTH/8-1:0] byte_en;
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    valid_out;
  logic                    ready;
  logic                    addr_err;

  modport master (
    output en, wr_en, byte_en, address, data_in,
    input  data_out, valid_out, ready, addr_err
  );

  modport slave (
    input  en, wr_en, byte_en, address, data_in,
    output data_out, valid_out, ready, addr_err
  );
endinterface

// File: rtl/param_sp_memory.sv
// Parametrised single-port memory: byte-lane writes, pipelined reads with aligned
// valid, post-reset zero-fill sequencer and sticky out-of-range flag.
module param_sp_memory #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int DEPTH         = 16,
  parameter int READ_LATENCY  = 1,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic              clk,
  input logic              rst,
  param_sp_memory_if.slave bus
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
  logic                    addr_err_q, addr_err_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [NUM_LANES-1:0]    mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_waddr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_d;

  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [DATA_WIDTH-1:0]   dat_pipe_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   dat_pipe_d [READ_LATENCY];

  logic                    ready;
  logic                    accept;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign ready    = (state_q == ST_RUN);
  assign accept   = bus.en && ready && !rst;
  assign in_range = {1'b0, bus.address} < DEPTH_W;
  assign rd_word  = in_range ? mem_q[bus.address] : '0;

  // Sequencer and write port: INIT owns the write port until the last word is zeroed.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    addr_err_d  = addr_err_q;
    mem_we_d    = '0;
    mem_waddr_d = bus.address;
    mem_wdata_d = bus.data_in;
    case (state_q)
      ST_INIT: begin
        mem_we_d    = rst ? '0 : '1;
        mem_waddr_d = init_cnt_q;
        mem_wdata_d = '0;
        init_cnt_d  = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_W) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept && !in_range) addr_err_d = 1'b1;
        if (accept && bus.wr_en && in_range) mem_we_d = bus.byte_en;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage is deliberately not reset; zero-fill is the sequencer's job.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (mem_we_d[i]) mem_q[mem_waddr_d][8*i +: 8] <= mem_wdata_d[8*i +: 8];
  end

  // Read pipe: the final stage only loads on a valid beat so data_out holds between reads.
  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[0] = accept && !bus.wr_en;
    dat_pipe_d[0] = rd_word;
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      dat_pipe_d[k] = dat_pipe_q[k-1];
    end
    if (!vld_pipe_d[READ_LATENCY-1])
      dat_pipe_d[READ_LATENCY-1] = dat_pipe_q[READ_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) dat_pipe_q[k] <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_pipe_q <= dat_pipe_d;
    end
  end

  assign bus.data_out  = dat_pipe_q[READ_LATENCY-1];
  assign bus.valid_out = vld_pipe_q[READ_LATENCY-1];
  assign bus.ready     = ready;
  assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_param_sp_memory.sv
// Bench for param_sp_memory: directed scenarios plus random traffic, every cycle
// compared against a word-array/read-queue model of the memory's observable behaviour.
module tb_param_sp_memory;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int DEP = 12;
  localparam int RL  = 3;
  localparam int NL  = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_sp_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  param_sp_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP),
    .READ_LATENCY(RL), .INIT_ON_RESET(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] ref_mem [DEP];
  rd_t           rq[$];
  int            edge_n    = 0;
  int            init_left = DEP;
  bit            err_m     = 1'b0;
  logic [DW-1:0] last_m    = '0;
  logic [DW-1:0] seen[$];
  int            seen_edge[$];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // One clock: drive request, advance model at the edge, check all outputs at negedge.
  // The negedge after edge k lies in cycle k+1, where a request in cycle c ends at edge c.
  task automatic tick(input bit r, input bit e, input bit w, input logic [NL-1:0] be,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_t t;
    bit  exp_v;
    rst = r; bus.en = e; bus.wr_en = w; bus.byte_en = be; bus.address = a; bus.data_in = d;
    @(posedge clk);
    edge_n++;
    if (r) begin
      for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
      rq.delete();
      init_left = DEP;
      err_m     = 1'b0;
      last_m    = '0;
    end else begin
      if (init_left == 0 && e) begin
        if (int'(a) >= DEP) begin
          err_m = 1'b1;
          if (!w) begin t.due = edge_n + RL - 1; t.data = '0; rq.push_back(t); end
        end else if (w) begin
          for (int i = 0; i < NL; i++) if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end else begin
          t.due = edge_n + RL - 1; t.data = ref_mem[a]; rq.push_back(t);
        end
      end
      if (init_left > 0) init_left--;
    end
    @(negedge clk);
    exp_v = 1'b0;
    if (rq.size() > 0) begin
      if (rq[0].due == edge_n) begin
        exp_v  = 1'b1;
        last_m = rq[0].data;
        void'(rq.pop_front());
      end
    end
    chk("valid_out", 64'(bus.valid_out), 64'(exp_v));
    chk("data_out",  64'(bus.data_out),  64'(last_m));
    chk("ready",     64'(bus.ready),     64'(init_left == 0));
    chk("addr_err",  64'(bus.addr_err),  64'(err_m));
    if (bus.valid_out === 1'b1) begin
      seen.push_back(bus.data_out);
      seen_edge.push_back(edge_n);
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    tick(1'b0, 1'b1, 1'b1, be, a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    tick(1'b0, 1'b1, 1'b0, '0, a, '0);
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    seen.delete();
    rd(a);
    repeat (RL) idle();
    chk({tag, "_n"}, 64'(seen.size()), 64'd1);
    chk(tag, 64'(bus.data_out), 64'(exp));
  endtask

  initial begin
    int n_low;
    int e0;
    bus.en = 1'b0; bus.wr_en = 1'b0; bus.byte_en = '0; bus.address = '0; bus.data_in = '0;

    // Reset with reads held on, then a stray write during INIT that must be ignored.
    seen.delete();
    tick(1'b1, 1'b1, 1'b0, '0, 4'd5, '0);
    n_low = (bus.ready === 1'b0) ? 1 : 0;
    for (int i = 0; i < DEP; i++) begin
      if (i == 4) wr(4'd7, 32'hFFFF_FFFF, '1);
      else        rd(AW'(i));
      if (bus.ready === 1'b0) n_low++;
    end
    chk("init_len", 64'(n_low), 64'(DEP));
    chk("init_no_valid", 64'(seen.size()), 64'd0);
    rd_chk("init_a5", 4'd5, 32'h0);
    rd_chk("init_wr_ignored", 4'd7, 32'h0);

    // Byte-lane merge.
    wr(4'd3, 32'hAABB_CCDD, 4'b1111);
    wr(4'd3, 32'h1122_3344, 4'b0101);
    wr(4'd3, 32'h9999_9999, 4'b0000);
    rd_chk("byte_lane", 4'd3, 32'hAA22_CC44);

    // Back-to-back reads at full latency.
    for (int i = 0; i < 4; i++) wr(AW'(i), 32'h10 + i, '1);
    seen.delete(); seen_edge.delete();
    e0 = edge_n + 1;
    for (int i = 0; i < 4; i++) rd(AW'(i));
    repeat (RL) idle();
    chk("lat_count", 64'(seen.size()), 64'd4);
    if (seen.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("lat_edge", 64'(seen_edge[i]), 64'(e0 + RL - 1 + i));
        chk("lat_data", 64'(seen[i]), 64'(32'h10 + i));
      end
    end

    // Read-after-write, and write-after-read not disturbing captured data.
    wr(4'd7, 32'h5A5A_5A5A, '1);
    rd_chk("raw", 4'd7, 32'h5A5A_5A5A);
    seen.delete();
    rd(4'd7);
    wr(4'd7, 32'hCAFE_F00D, '1);
    repeat (RL) idle();
    chk("war_data", 64'(bus.data_out), 64'h5A5A_5A5A);
    rd_chk("war_new", 4'd7, 32'hCAFE_F00D);

    // Out-of-range: dropped write, zero read, sticky flag.
    wr(4'd1, 32'h1234_5678, '1);
    wr(4'd13, 32'hDEAD_BEEF, '1);
    chk("oor_err", 64'(bus.addr_err), 64'd1);
    rd_chk("oor_rd", 4'd13, 32'h0);
    rd_chk("oor_keep1", 4'd1, 32'h1234_5678);
    chk("oor_sticky", 64'(bus.addr_err), 64'd1);

    // Random traffic across the whole address space.
    for (int i = 0; i < 400; i++)
      tick(1'b0, ($urandom % 4) != 0, $urandom_range(0, 1) == 1, NL'($urandom),
           AW'($urandom_range(0, 15)), $urandom);
    repeat (RL) idle();

    // Reset with reads in flight: nothing may come out, and memory is zeroed again.
    seen.delete();
    rd(4'd2);
    rd(4'd3);
    tick(1'b1, 1'b0, 1'b0, '0, '0, '0);
    chk("rst_err_clr", 64'(bus.addr_err), 64'd0);
    for (int i = 0; i < DEP; i++)
      tick(1'b0, 1'b1, $urandom_range(0, 1) == 1, '1, AW'($urandom_range(0, 15)), $urandom);
    chk("rst_flush", 64'(seen.size()), 64'd0);
    for (int i = 0; i < DEP; i++) rd_chk("post_rst_zero", AW'(i), 32'h0);

    // Short random burst after re-init.
    for (int i = 0; i < 100; i++)
      tick(1'b0, ($urandom % 3) != 0, $urandom_range(0, 1) == 1, NL'($urandom),
           AW'($urandom_range(0, 15)), $urandom);
    repeat (RL) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
